// File: rtl/idex_pipe.sv
// ID/EX pipeline register with valid/ready handshake, flush, operand
// forwarding from MEM/WB, operand muxing and a saturating bubble counter.
module idex_pipe #(
  parameter int WordSize = 32,
  parameter int RegBits  = 5,
  parameter int CntBits  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                flush,
  input  logic [1:0]          a_sel,
  input  logic [1:0]          b_sel,
  input  logic                branch_taken_in,
  input  logic [WordSize-1:0] pc_in,
  input  logic [WordSize-1:0] imm,
  input  logic [WordSize-1:0] rs1d,
  input  logic [WordSize-1:0] rs2d_in,
  input  logic [WordSize-1:0] branch_addr_in,
  input  logic [RegBits-1:0]  rs1n,
  input  logic [RegBits-1:0]  rs2n,
  input  logic [RegBits-1:0]  rdn_in,
  input  logic                fwd_mem_en,
  input  logic [RegBits-1:0]  fwd_mem_rdn,
  input  logic [WordSize-1:0] fwd_mem_data,
  input  logic                fwd_wb_en,
  input  logic [RegBits-1:0]  fwd_wb_rdn,
  input  logic [WordSize-1:0] fwd_wb_data,
  output logic [WordSize-1:0] a,
  output logic [WordSize-1:0] b,
  output logic [WordSize-1:0] rs2d,
  output logic [WordSize-1:0] pc,
  output logic [WordSize-1:0] branch_addr,
  output logic [RegBits-1:0]  rdn,
  output logic                branch_taken,
  output logic [CntBits-1:0]  bubble_cnt
);

  logic                r_valid;
  logic [WordSize-1:0] r_a, r_b, r_rs2d, r_pc, r_branch_addr;
  logic [RegBits-1:0]  r_rdn;
  logic                r_branch_taken;
  logic [CntBits-1:0]  r_bubble_cnt;

  logic [WordSize-1:0] w_rs1_eff, w_rs2_eff, w_a_next, w_b_next;
  logic                w_in_ready, w_load, w_bubble;

  assign w_in_ready = !r_valid || out_ready;
  assign w_load     = in_valid && w_in_ready && !flush;
  // Flush counts as a bubble even when it overrides a stall.
  assign w_bubble   = flush || (w_in_ready && !in_valid);

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    w_rs1_eff = rs1d;
    if (rs1n != '0 && fwd_mem_en && fwd_mem_rdn == rs1n)
      w_rs1_eff = fwd_mem_data;
    else if (rs1n != '0 && fwd_wb_en && fwd_wb_rdn == rs1n)
      w_rs1_eff = fwd_wb_data;
  end

  always_comb begin
    w_rs2_eff = rs2d_in;
    if (rs2n != '0 && fwd_mem_en && fwd_mem_rdn == rs2n)
      w_rs2_eff = fwd_mem_data;
    else if (rs2n != '0 && fwd_wb_en && fwd_wb_rdn == rs2n)
      w_rs2_eff = fwd_wb_data;
  end

  always_comb begin
    w_a_next = '0;
    case (a_sel)
      2'd0:    w_a_next = w_rs1_eff;
      2'd1:    w_a_next = pc_in;
      default: w_a_next = '0;
    endcase
  end

  always_comb begin
    w_b_next = '0;
    case (b_sel)
      2'd0:    w_b_next = w_rs2_eff;
      2'd1:    w_b_next = imm;
      2'd2:    w_b_next = WordSize'(4);
      default: w_b_next = imm << 12;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid        <= 1'b0;
      r_a            <= '0;
      r_b            <= '0;
      r_rs2d         <= '0;
      r_pc           <= '0;
      r_branch_addr  <= '0;
      r_rdn          <= '0;
      r_branch_taken <= 1'b0;
      r_bubble_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_valid        <= 1'b1;
        r_a            <= w_a_next;
        r_b            <= w_b_next;
        r_rs2d         <= w_rs2_eff;
        r_pc           <= pc_in;
        r_branch_addr  <= branch_addr_in;
        r_rdn          <= rdn_in;
        r_branch_taken <= branch_taken_in;
      end else if (w_bubble) begin
        r_valid <= 1'b0;
      end
      if (w_bubble && r_bubble_cnt != '1)
        r_bubble_cnt <= r_bubble_cnt + CntBits'(1);
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_valid;
  assign a            = r_a;
  assign b            = r_b;
  assign rs2d         = r_rs2d;
  assign pc           = r_pc;
  assign branch_addr  = r_branch_addr;
  assign rdn          = r_rdn;
  assign branch_taken = r_branch_taken;
  assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_idex_pipe.sv
// Scoreboard bench for idex_pipe: bundles are predicted at acceptance and
// compared when consumed; a second instance with a 2-bit counter checks saturation.
module tb_idex_pipe;

  typedef struct packed {
    logic [31:0] a, b, rs2d, pc, ba;
    logic [4:0]  rdn;
    logic        bt;
  } bundle_t;

  logic clk = 1'b0;
  logic rstn;
  logic in_valid, out_ready, flush, branch_taken_in;
  logic [1:0]  a_sel, b_sel;
  logic [31:0] pc_in, imm, rs1d, rs2d_in, branch_addr_in;
  logic [4:0]  rs1n, rs2n, rdn_in;
  logic        fwd_mem_en, fwd_wb_en;
  logic [4:0]  fwd_mem_rdn, fwd_wb_rdn;
  logic [31:0] fwd_mem_data, fwd_wb_data;

  logic        in_ready, out_valid, branch_taken;
  logic [31:0] a, b, rs2d, pc, branch_addr;
  logic [4:0]  rdn;
  logic [15:0] bubble_cnt;

  logic        s_in_ready, s_out_valid, s_branch_taken;
  logic [31:0] s_a, s_b, s_rs2d, s_pc, s_branch_addr;
  logic [4:0]  s_rdn;
  logic [1:0]  s_bubble_cnt;
  logic        s_in_valid = 1'b0;
  logic        s_out_ready = 1'b1;
  logic        s_flush = 1'b0;

  always #5 clk = ~clk;

  idex_pipe dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .a_sel(a_sel), .b_sel(b_sel), .branch_taken_in(branch_taken_in),
    .pc_in(pc_in), .imm(imm), .rs1d(rs1d), .rs2d_in(rs2d_in),
    .branch_addr_in(branch_addr_in), .rs1n(rs1n), .rs2n(rs2n), .rdn_in(rdn_in),
    .fwd_mem_en(fwd_mem_en), .fwd_mem_rdn(fwd_mem_rdn), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_en(fwd_wb_en), .fwd_wb_rdn(fwd_wb_rdn), .fwd_wb_data(fwd_wb_data),
    .a(a), .b(b), .rs2d(rs2d), .pc(pc), .branch_addr(branch_addr), .rdn(rdn),
    .branch_taken(branch_taken), .bubble_cnt(bubble_cnt)
  );

  idex_pipe #(.CntBits(2)) dut_sat (
    .clk(clk), .rstn(rstn), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .flush(s_flush),
    .a_sel(a_sel), .b_sel(b_sel), .branch_taken_in(branch_taken_in),
    .pc_in(pc_in), .imm(imm), .rs1d(rs1d), .rs2d_in(rs2d_in),
    .branch_addr_in(branch_addr_in), .rs1n(rs1n), .rs2n(rs2n), .rdn_in(rdn_in),
    .fwd_mem_en(fwd_mem_en), .fwd_mem_rdn(fwd_mem_rdn), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_en(fwd_wb_en), .fwd_wb_rdn(fwd_wb_rdn), .fwd_wb_data(fwd_wb_data),
    .a(s_a), .b(s_b), .rs2d(s_rs2d), .pc(s_pc), .branch_addr(s_branch_addr), .rdn(s_rdn),
    .branch_taken(s_branch_taken), .bubble_cnt(s_bubble_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  bundle_t     exp_q[$];
  bundle_t     m_hold;
  logic        m_valid;
  logic [15:0] m_cnt;
  logic [1:0]  s_cnt;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] eff(input logic [4:0] n, input logic [31:0] d);
    if (n != 5'd0 && fwd_mem_en && fwd_mem_rdn == n) return fwd_mem_data;
    if (n != 5'd0 && fwd_wb_en && fwd_wb_rdn == n) return fwd_wb_data;
    return d;
  endfunction

  function automatic bundle_t predict();
    bundle_t r;
    logic [31:0] sh;
    sh = imm << 12;
    r.rs2d = eff(rs2n, rs2d_in);
    case (a_sel)
      2'd0: r.a = eff(rs1n, rs1d);
      2'd1: r.a = pc_in;
      default: r.a = 32'd0;
    endcase
    case (b_sel)
      2'd0: r.b = r.rs2d;
      2'd1: r.b = imm;
      2'd2: r.b = 32'd4;
      default: r.b = sh;
    endcase
    r.pc = pc_in; r.ba = branch_addr_in; r.rdn = rdn_in; r.bt = branch_taken_in;
    return r;
  endfunction

  task automatic check_data(input string tag, input bundle_t e);
    check_val({tag, ".a"}, a, e.a);
    check_val({tag, ".b"}, b, e.b);
    check_val({tag, ".rs2d"}, rs2d, e.rs2d);
    check_val({tag, ".pc"}, pc, e.pc);
    check_val({tag, ".branch_addr"}, branch_addr, e.ba);
    check_val({tag, ".rdn"}, rdn, e.rdn);
    check_val({tag, ".branch_taken"}, branch_taken, e.bt);
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_hold = '0; m_valid = 1'b0; m_cnt = 16'd0; s_cnt = 2'd0;
  endfunction

  // Inputs are driven at posedge+1; compare at posedge+4, then advance the model.
  task automatic cycle();
    bundle_t e;
    logic rdy;
    #3;
    rdy = !m_valid || out_ready;
    check_val("in_ready", in_ready, rdy);
    check_val("out_valid", out_valid, m_valid);
    check_val("bubble_cnt", bubble_cnt, m_cnt);
    check_val("sat_bubble_cnt", s_bubble_cnt, s_cnt);
    if (!m_valid) check_data("held", m_hold);
    if (flush) begin
      if (m_valid) begin
        e = exp_q.pop_front();
        $display("flush: discard pc=0x%0h", e.pc);
      end
      m_valid = 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt++;
    end else if (rdy) begin
      if (m_valid) begin
        if (exp_q.size() == 0) check_val("scoreboard_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_data("consume", e);
          $display("consume: a=0x%0h b=0x%0h rs2d=0x%0h pc=0x%0h rdn=%0d", a, b, rs2d, pc, rdn);
        end
      end
      if (in_valid) begin
        e = predict();
        exp_q.push_back(e);
        m_hold = e;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
    end else if (m_valid && exp_q.size() != 0) begin
      check_data("stall", exp_q[0]);
    end
    if (s_cnt != 2'd3) s_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 1; flush = 0; a_sel = 0; b_sel = 0; branch_taken_in = 0;
    pc_in = 0; imm = 0; rs1d = 0; rs2d_in = 0; branch_addr_in = 0;
    rs1n = 0; rs2n = 0; rdn_in = 0;
    fwd_mem_en = 0; fwd_mem_rdn = 0; fwd_mem_data = 0;
    fwd_wb_en = 0; fwd_wb_rdn = 0; fwd_wb_data = 0;
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("reset.out_valid", out_valid, 0);
    check_val("reset.bubble_cnt", bubble_cnt, 0);
    check_data("reset", '0);
    rstn = 1'b1;

    // Load with b = imm << 12
    in_valid = 1; a_sel = 1; b_sel = 3; pc_in = 32'h100; imm = 32'h12345;
    rdn_in = 7; branch_addr_in = 32'h2000; branch_taken_in = 1;
    cycle();
    imm = 32'h45; pc_in = 32'h104;
    cycle();
    in_valid = 0;
    cycle();

    // Forward priority on rs1, then rs2 via b_sel 0
    in_valid = 1; a_sel = 0; b_sel = 0; rs1n = 5; rs1d = 32'h11;
    rs2n = 5; rs2d_in = 32'h22;
    fwd_mem_en = 1; fwd_mem_rdn = 5; fwd_mem_data = 32'hAA;
    fwd_wb_en = 1; fwd_wb_rdn = 5; fwd_wb_data = 32'hBB;
    cycle();
    fwd_mem_en = 0;
    cycle();
    rs1n = 0; rs2n = 0; fwd_mem_en = 1; fwd_mem_rdn = 0; fwd_wb_rdn = 0;
    cycle();
    rs1n = 3; rs2n = 9; fwd_mem_rdn = 9; fwd_wb_rdn = 3; b_sel = 2;
    cycle();

    // Stall: new bundle offered, forwarding sources change meanwhile
    out_ready = 0; rs1n = 4; fwd_wb_rdn = 4; fwd_wb_data = 32'hCC; pc_in = 32'h300;
    cycle();
    fwd_wb_data = 32'hDD;
    cycle();
    cycle();
    cycle();
    out_ready = 1;
    cycle();
    in_valid = 0;
    cycle();

    // Flush with a bundle held and another offered
    in_valid = 1; pc_in = 32'h400; a_sel = 1;
    cycle();
    out_ready = 0; flush = 1; pc_in = 32'h500;
    cycle();
    flush = 0; out_ready = 1; in_valid = 0;
    cycle();
    cycle();

    // Random traffic with small register numbers to hit forwarding often
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 9) == 0);
      a_sel = 2'($urandom_range(0, 3)); b_sel = 2'($urandom_range(0, 3));
      branch_taken_in = 1'($urandom_range(0, 1));
      pc_in = $urandom; imm = $urandom; rs1d = $urandom; rs2d_in = $urandom;
      branch_addr_in = $urandom;
      rs1n = 5'($urandom_range(0, 3)); rs2n = 5'($urandom_range(0, 3));
      rdn_in = 5'($urandom_range(0, 31));
      fwd_mem_en = 1'($urandom_range(0, 1)); fwd_mem_rdn = 5'($urandom_range(0, 3));
      fwd_mem_data = $urandom;
      fwd_wb_en = 1'($urandom_range(0, 1)); fwd_wb_rdn = 5'($urandom_range(0, 3));
      fwd_wb_data = $urandom;
      cycle();
    end

    // Asynchronous reset in the middle of a stall
    flush = 0; in_valid = 1; out_ready = 1; a_sel = 1; pc_in = 32'h777;
    cycle();
    out_ready = 0;
    cycle();
    #3 rstn = 1'b0;
    #1;
    check_val("async.out_valid", out_valid, 0);
    check_val("async.in_ready", in_ready, 1);
    check_val("async.bubble_cnt", bubble_cnt, 0);
    check_data("async", '0);
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    cycle();
    in_valid = 0; out_ready = 1;
    cycle();
    for (int i = 0; i < 6; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
